// File: rtl/wii_cam_pkg.sv
// Shared constants, state encoding and init ROM for the Wii IR camera sequencer.
// Optional poll loop after init is enabled with CAM_POLL_EN.
package wii_cam_pkg;

  localparam logic [6:0] CAM_ADDR = 7'h58;
  localparam int         INIT_LEN = 6;
  localparam logic [7:0] POLL_REG = 8'h36;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ISSUE     = ST_ISSUE,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_GAP       = ST_GAP,
    S_DONE      = ST_DONE
  } state_t;

  // Returns {packets[4:0], data[15:0]} for one init write.
  function automatic logic [20:0] init_entry(input logic [2:0] idx);
    logic [20:0] e;
    unique case (idx)
      3'd0:    e = {5'd2, 16'h3001};
      3'd1:    e = {5'd2, 16'h3008};
      3'd2:    e = {5'd2, 16'h0690};
      3'd3:    e = {5'd2, 16'h08C0};
      3'd4:    e = {5'd2, 16'h1A40};
      3'd5:    e = {5'd2, 16'h3333};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Down-counter shared by the settle gap and the busy timeout.
// load presets the count; expired is high while the count is zero.
module seq_gap_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: preset on load, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/wii_cam_init_seq.sv
// Command sequencer that feeds the Wii IR camera init writes to i2c_master.
// Define CAM_POLL_EN to follow init with an endless write-36 / read poll loop.
module wii_cam_init_seq
  import wii_cam_pkg::*;
#(
  parameter int DATA_BYTES   = 2,
  parameter int GAP_CYCLES   = 100000,
  parameter int BUSY_TIMEOUT = 64,
  parameter int READ_BYTES   = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    i2c_ready,
  output logic                    i2c_start,
  output logic [6:0]              i2c_addr,
  output logic [DATA_BYTES*8-1:0] i2c_data,
  output logic [4:0]              packets,
  output logic                    rw,
  output logic                    busy,
  output logic                    init_done,
  output logic                    err,
  output logic [2:0]              step
);

  localparam int DW   = DATA_BYTES * 8;
  localparam int TMAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic [DW-1:0] data_q, data_d;
  logic [4:0]    pkts_q, pkts_d;
  logic          rw_q, rw_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [2:0]    step_q, step_d;
  logic          adv_q, adv_d;
  logic          poll_q, poll_d;
  logic          rd_q, rd_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_exp;
  logic [20:0]   ent;

  // Left-justify a two-byte payload in the flat data bus.
  function automatic logic [DW-1:0] place(input logic [15:0] v);
    return DW'(v) << (DW - 16);
  endfunction

  seq_gap_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    data_d   = data_q;
    pkts_d   = pkts_q;
    rw_d     = rw_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    step_d   = step_q;
    adv_d    = adv_q;
    poll_d   = poll_q;
    rd_d     = rd_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    ent      = '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_ISSUE;
          step_d  = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          rw_d    = 1'b0;
          ent     = init_entry(3'd0);
          pkts_d  = ent[20:16];
          data_d  = place(ent[15:0]);
        end
      end
      S_ISSUE: begin
        if (i2c_ready) begin
          start_d  = 1'b1;
          state_d  = S_WAIT_BUSY;
          tmr_load = 1'b1;
          tmr_val  = TW'(BUSY_TIMEOUT - 1);
        end
      end
      S_WAIT_BUSY: begin
        if (!i2c_ready) begin
          state_d = S_WAIT_DONE;
        end else if (tmr_exp) begin
          err_d    = 1'b1;
          adv_d    = 1'b0;
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES - 1);
        end
      end
      S_WAIT_DONE: begin
        if (i2c_ready) begin
          adv_d    = 1'b1;
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (tmr_exp) begin
          state_d = S_ISSUE;
          if (adv_q) begin
            if (poll_q) begin
              rd_d = !rd_q;
              if (!rd_q) begin
                pkts_d = 5'(READ_BYTES);
                rw_d   = 1'b1;
                data_d = '0;
              end else begin
                pkts_d = 5'd1;
                rw_d   = 1'b0;
                data_d = place({POLL_REG, 8'h00});
              end
            end else if (step_q == 3'(INIT_LEN - 1)) begin
              done_d = 1'b1;
`ifdef CAM_POLL_EN
              poll_d = 1'b1;
              rd_d   = 1'b0;
              pkts_d = 5'd1;
              rw_d   = 1'b0;
              data_d = place({POLL_REG, 8'h00});
`else
              state_d = S_DONE;
              busy_d  = 1'b0;
`endif
            end else begin
              step_d = step_q + 3'd1;
              ent    = init_entry(step_q + 3'd1);
              pkts_d = ent[20:16];
              data_d = place(ent[15:0]);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
      pkts_q  <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
      adv_q   <= 1'b0;
      poll_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      data_q  <= data_d;
      pkts_q  <= pkts_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      step_q  <= step_d;
      adv_q   <= adv_d;
      poll_q  <= poll_d;
      rd_q    <= rd_d;
    end
  end

  assign i2c_start = start_q;
  assign i2c_addr  = CAM_ADDR;
  assign i2c_data  = data_q;
  assign packets   = pkts_q;
  assign rw        = rw_q;
  assign busy      = busy_q;
  assign init_done = done_q;
  assign err       = err_q;
  assign step      = step_q;

endmodule

// File: tb/tb_wii_cam_init_seq.sv
// Bench for wii_cam_init_seq with a behavioural i2c_master and a transaction scoreboard.
// Build with CAM_POLL_EN defined to exercise the poll loop.
module tb_wii_cam_init_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        i2c_ready;
  logic        i2c_start;
  logic [6:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic [4:0]  packets;
  logic        rw;
  logic        busy;
  logic        init_done;
  logic        err;
  logic [2:0]  step;

  logic        mdl_rdy;
  logic        stuck;
  logic        hold_low;
  int          busy_cnt;
  int          n_start = 0;
  int          n_chk   = 0;
  int          n_pass  = 0;
  logic [21:0] sb[$];

  always #5 clk = ~clk;

  assign i2c_ready = mdl_rdy & ~hold_low;

  wii_cam_init_seq #(
    .DATA_BYTES   (2),
    .GAP_CYCLES   (4),
    .BUSY_TIMEOUT (64),
    .READ_BYTES   (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .i2c_ready (i2c_ready),
    .i2c_start (i2c_start),
    .i2c_addr  (i2c_addr),
    .i2c_data  (i2c_data),
    .packets   (packets),
    .rw        (rw),
    .busy      (busy),
    .init_done (init_done),
    .err       (err),
    .step      (step)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [21:0] rec(input logic r, input logic [4:0] p,
                                      input logic [15:0] d);
    return {r, p, d};
  endfunction

  task automatic push_init();
    logic [15:0] tbl [6];
    tbl = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3333};
    for (int i = 0; i < 6; i++) sb.push_back(rec(1'b0, 5'd2, tbl[i]));
  endtask

  task automatic go_pulse();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    for (int i = 0; i < lim && !(init_done && sb.size() == 0); i++)
      @(negedge clk);
    chk(tag, {31'd0, init_done && sb.size() == 0}, 32'd1);
  endtask

  // i2c_master model: ready drops after a start and returns 10 cycles later.
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) mdl_rdy = 1'b1;
    end else if (i2c_start && !stuck && !reset) begin
      mdl_rdy  = 1'b0;
      busy_cnt = 10;
    end
  end

  // Every start pulse must match the next expected transaction.
  always @(negedge clk) begin
    if (i2c_start) begin
      n_start++;
      if (sb.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else chk("xfer", {10'd0, rw, packets, i2c_data}, {10'd0, sb.pop_front()});
    end
  end

  initial begin
    int k;
    reset    = 1'b1;
    go       = 1'b0;
    stuck    = 1'b0;
    hold_low = 1'b0;
    mdl_rdy  = 1'b1;
    busy_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", {31'd0, i2c_start}, 32'd0);
    chk("rst_data", {16'd0, i2c_data}, 32'd0);
    chk("rst_pkts", {27'd0, packets}, 32'd0);
    chk("rst_rw", {31'd0, rw}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_step", {29'd0, step}, 32'd0);
    chk("addr", {25'd0, i2c_addr}, 32'h58);
    reset = 1'b0;

    push_init();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    @(negedge clk);
    chk("latency", {31'd0, i2c_start}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(400, "t1_done");

`ifdef CAM_POLL_EN
    for (int i = 0; i < 2; i++) begin
      sb.push_back(rec(1'b0, 5'd1, 16'h3600));
      sb.push_back(rec(1'b1, 5'd12, 16'h0000));
    end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("poll_sb", sb.size(), 32'd0);
    chk("poll_done", {31'd0, init_done}, 32'd1);
    chk("poll_busy", {31'd0, busy}, 32'd1);
`else
    chk("t1_step", {29'd0, step}, 32'd5);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);

    push_init();
    go_pulse();
    for (int i = 0; i < 200 && step != 3'd2; i++) @(negedge clk);
    chk("t3_at2", {29'd0, step}, 32'd2);
    go_pulse();
    wait_done(400, "t3_done");
    push_init();
    go_pulse();
    wait_done(400, "t3_rerun");

    push_init();
    go_pulse();
    for (int i = 0; i < 200 && !(step == 3'd3 && !i2c_ready); i++)
      @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_start", {31'd0, i2c_start}, 32'd0);
    chk("t4_step", {29'd0, step}, 32'd0);
    chk("t4_data", {16'd0, i2c_data}, 32'd0);
    chk("t4_sb", sb.size(), 32'd2);
    sb.delete();
    repeat (15) @(negedge clk);
    reset = 1'b0;
    push_init();
    go_pulse();
    wait_done(400, "t4_restart");

    push_init();
    hold_low = 1'b1;
    k = n_start;
    go_pulse();
    repeat (10) @(negedge clk);
    chk("t6_nostart", n_start - k, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    hold_low = 1'b0;
    wait_done(400, "t6_done");
    chk("t6_count", n_start - k, 32'd6);

    sb.push_back(rec(1'b0, 5'd2, 16'h3001));
    stuck = 1'b1;
    go_pulse();
    for (int i = 0; i < 200 && !err; i++) @(negedge clk);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_step", {29'd0, step}, 32'd0);
    stuck = 1'b0;
    push_init();
    wait_done(600, "t2_done");
    chk("t2_sticky", {31'd0, err}, 32'd1);
    push_init();
    go_pulse();
    chk("t2_clr", {31'd0, err}, 32'd0);
    wait_done(400, "t2_rerun");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
